scan_pat_engine: RTL and testbench
==================================

SCAN_PAT_ENGINE -- requirements
Module: scan_pat_engine

Interface
REQ-001 Parameter NCHAIN, default 4, number of parallel scan chains (1..16).
REQ-002 Parameter CHAIN_LEN, default 128, shift cycles per load/unload (2..4096).
REQ-003 Parameter CAP_CYC, default 1, capture cycles per pattern (1..4).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 start  in  1  one-cycle pulse; begins a run of num_pat patterns; ignored unless IDLE or DONE.
REQ-007 abort  in  1  terminates run; wins over all other events.
REQ-008 num_pat  in  16  patterns per run, sampled on start; 0 means go directly to DONE.
REQ-009 stim_valid / stim_ready  in / out  1 / 1  per-shift-vector handshake; transfer when both high.
REQ-010 stim_si, stim_exp, stim_msk  in  NCHAIN each  scan-in bits, expected scan-out, compare mask (1 = compare).
REQ-011 scan_en, scan_ce  out  1, 1  shift-mode select; chain clock-enable, high exactly on shift or capture cycles.
REQ-012 scan_si  out  NCHAIN  chain inputs; scan_so  in  NCHAIN  chain outputs.
REQ-013 busy, done  out  1, 1  run active; run complete (held until next start or rst).
REQ-014 pat_num  out  16  current pattern index, 0-based; vec_num  out  32  total shift+capture cycles issued.
REQ-015 fail_cnt  out  16  miscompared bits, saturating; ff_pat 16, ff_vec 32, ff_chain NCHAIN  first-fail record; ff_vld  out  1.

Function
REQ-016 States: IDLE, LOAD, CAPTURE, SHIFT (overlapped unload/load), UNLOAD, DONE.
REQ-017 IDLE --start, num_pat>0--> LOAD; IDLE --start, num_pat=0--> DONE.
REQ-018 LOAD: CHAIN_LEN transfers, scan_si=stim_si, scan_en=1, comparisons disabled (first unload is don't-care).
REQ-019 CAPTURE: CAP_CYC cycles, scan_en=0, scan_ce=1, stim_ready=0; then pat_num+1 and SHIFT if patterns remain, else UNLOAD.
REQ-020 SHIFT: CHAIN_LEN transfers loading next pattern and comparing previous, then CAPTURE.
REQ-021 UNLOAD: CHAIN_LEN transfers, scan_si=0, stim_si ignored, comparisons enabled; then DONE.
REQ-022 In LOAD/SHIFT/UNLOAD stim_ready=1; scan_ce=1 only in cycles with stim_valid=1; stall holds scan_en=1, scan_ce=0, counters frozen.
REQ-023 scan_si is combinational from stim_si in transfer cycles; scan_so is sampled in the same cycle, before the chain shifts.
REQ-024 Compare: miss = (scan_so ^ stim_exp) & stim_msk; fail_cnt += popcount(miss) one cycle later, saturating at 0xFFFF.
REQ-025 First nonzero miss sets ff_vld=1 and captures pat_num (of the pattern being unloaded), vec_num and miss; later fails do not overwrite.
REQ-026 vec_num increments on every scan_ce cycle; bit-shift counter wraps at CHAIN_LEN-1 -> 0 with state change on the same edge.
REQ-027 abort: next cycle IDLE, scan_en=0, scan_ce=0, busy=0, done=0; fail record and counters preserved.
REQ-028 start while busy ignored; start in DONE clears done, counters and fail record, then enters LOAD.
REQ-029 busy=1 in LOAD, CAPTURE, SHIFT, UNLOAD only.

Reset
REQ-030 On rst: state IDLE; scan_en, scan_ce, stim_ready, busy, done, ff_vld = 0; scan_si = 0; pat_num, vec_num, fail_cnt, ff_pat, ff_vec, ff_chain = 0.
REQ-031 rst asserted mid-run takes effect on the next edge regardless of handshake state; no partial transfer is counted.

Structure
REQ-032 State enum, counter widths and saturation constant live in shared package scan_pkg.
REQ-033 One sub-module, scan_cmp: mask/compare, popcount, saturating accumulate, first-fail capture.

Verification
REQ-034 NCHAIN=4, CHAIN_LEN=8, num_pat=2, stim_valid held high, exp=so -> vec_num=8+1+8+1+8=26, fail_cnt=0, done=1, ff_vld=0.
REQ-035 Same run, so bit2 forced 1 against exp=0 on 3rd SHIFT vector -> fail_cnt=1, ff_pat=0, ff_vec=11, ff_chain=4'b0100.
REQ-036 stim_valid low for 5 cycles mid-LOAD -> scan_ce=0 and vec_num frozen for those cycles, final vec_num still 26.
REQ-037 Masked miscompares (msk=0) on every bit of one pattern -> fail_cnt=0; all-bits miscompare over 20000 vectors -> fail_cnt=0xFFFF.
REQ-038 abort in SHIFT -> IDLE next cycle, done=0; rst mid-UNLOAD -> all outputs at REQ-030 values next cycle.
REQ-039 num_pat=0 start -> DONE next cycle with vec_num=0; start while busy -> no change in pat_num or vec_num.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared state encoding, counter widths and helpers for the scan pattern engine.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_DONE    = 3'd5
  } scan_state_e;

  localparam int PAT_W      = 16;
  localparam int VEC_W      = 32;
  localparam int CNT_W      = 16;
  localparam int MAX_NCHAIN = 16;
  localparam logic [CNT_W-1:0] FAIL_SAT = 16'hFFFF;

  function automatic logic [4:0] popcount16(input logic [MAX_NCHAIN-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < MAX_NCHAIN; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/scan_cmp.sv
// Masked scan-out compare with a one-cycle accumulate stage: saturating
// miscompare count plus a first-fail record that later fails never overwrite.
module scan_cmp
  import scan_pkg::*;
#(
  parameter int NCHAIN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              cmp_en_i,
  input  logic [NCHAIN-1:0] so_i,
  input  logic [NCHAIN-1:0] exp_i,
  input  logic [NCHAIN-1:0] msk_i,
  input  logic [PAT_W-1:0]  pat_i,
  input  logic [VEC_W-1:0]  vec_i,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic [PAT_W-1:0]  ff_pat_o,
  output logic [VEC_W-1:0]  ff_vec_o,
  output logic [NCHAIN-1:0] ff_chain_o,
  output logic              ff_vld_o
);

  logic [NCHAIN-1:0]     miss_s, miss_q;
  logic [MAX_NCHAIN-1:0] miss_ext_s;
  logic [PAT_W-1:0]      mpat_q;
  logic [VEC_W-1:0]      mvec_q;
  logic [CNT_W:0]        sum_s;
  logic [CNT_W-1:0]      fail_cnt_d, fail_cnt_q;
  logic [PAT_W-1:0]      ff_pat_q;
  logic [VEC_W-1:0]      ff_vec_q;
  logic [NCHAIN-1:0]     ff_chain_q;
  logic                  ff_vld_q;

  always_comb begin
    miss_s = cmp_en_i ? ((so_i ^ exp_i) & msk_i) : '0;
    miss_ext_s = '0;
    miss_ext_s[NCHAIN-1:0] = miss_q;
    sum_s = {1'b0, fail_cnt_q} + (CNT_W+1)'(popcount16(miss_ext_s));
    fail_cnt_d = sum_s[CNT_W] ? FAIL_SAT : sum_s[CNT_W-1:0];
  end

  // Stage 1 latches the miss vector with its pattern/vector tags; stage 2 accumulates.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      miss_q     <= '0;
      mpat_q     <= '0;
      mvec_q     <= '0;
      fail_cnt_q <= '0;
      ff_pat_q   <= '0;
      ff_vec_q   <= '0;
      ff_chain_q <= '0;
      ff_vld_q   <= 1'b0;
    end else begin
      miss_q     <= miss_s;
      mpat_q     <= pat_i;
      mvec_q     <= vec_i;
      fail_cnt_q <= fail_cnt_d;
      if ((miss_q != '0) && !ff_vld_q) begin
        ff_pat_q   <= mpat_q;
        ff_vec_q   <= mvec_q;
        ff_chain_q <= miss_q;
        ff_vld_q   <= 1'b1;
      end else begin
        ff_vld_q   <= ff_vld_q;
      end
    end
  end

  assign fail_cnt_o = fail_cnt_q;
  assign ff_pat_o   = ff_pat_q;
  assign ff_vec_o   = ff_vec_q;
  assign ff_chain_o = ff_chain_q;
  assign ff_vld_o   = ff_vld_q;

endmodule

// File: rtl/scan_pat_engine.sv
// Scan pattern sequencer: load, capture, overlapped shift, final unload, with
// a per-vector stimulus handshake and masked scan-out comparison.
module scan_pat_engine
  import scan_pkg::*;
#(
  parameter int NCHAIN    = 4,
  parameter int CHAIN_LEN = 128,
  parameter int CAP_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  num_pat,
  input  logic              stim_valid,
  output logic              stim_ready,
  input  logic [NCHAIN-1:0] stim_si,
  input  logic [NCHAIN-1:0] stim_exp,
  input  logic [NCHAIN-1:0] stim_msk,
  output logic              scan_en,
  output logic              scan_ce,
  output logic [NCHAIN-1:0] scan_si,
  input  logic [NCHAIN-1:0] scan_so,
  output logic              busy,
  output logic              done,
  output logic [PAT_W-1:0]  pat_num,
  output logic [VEC_W-1:0]  vec_num,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [PAT_W-1:0]  ff_pat,
  output logic [VEC_W-1:0]  ff_vec,
  output logic [NCHAIN-1:0] ff_chain,
  output logic              ff_vld
);

  localparam int BIT_W = $clog2(CHAIN_LEN);

  scan_state_e      state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [1:0]       cap_q, cap_d;
  logic [PAT_W-1:0] pat_q, pat_d, npat_q, npat_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [PAT_W:0]   pat_inc_s;
  logic             shift_q, busy_q, done_q;
  logic             shift_st_s, xfer_s, cap_s, scan_ce_s, start_ok_s, clr_s, cmp_en_s;

  // Abort suppresses any transfer or capture in its own cycle.
  always_comb begin
    shift_st_s = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
    xfer_s     = shift_st_s && stim_valid && !abort;
    cap_s      = (state_q == ST_CAPTURE) && !abort;
    scan_ce_s  = xfer_s || cap_s;
    start_ok_s = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    cmp_en_s   = xfer_s && ((state_q == ST_SHIFT) || (state_q == ST_UNLOAD));
    pat_inc_s  = {1'b0, pat_q} + 17'd1;
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    pat_d   = pat_q;
    vec_d   = vec_q;
    npat_d  = npat_q;
    clr_s   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      cap_d   = 2'd0;
    end else if (start_ok_s) begin
      clr_s   = 1'b1;
      npat_d  = num_pat;
      pat_d   = '0;
      vec_d   = '0;
      bit_d   = '0;
      cap_d   = 2'd0;
      state_d = (num_pat == 16'd0) ? ST_DONE : ST_LOAD;
    end else begin
      vec_d = scan_ce_s ? (vec_q + 32'd1) : vec_q;
      if (xfer_s) begin
        if (bit_q == BIT_W'(CHAIN_LEN - 1)) begin
          bit_d   = '0;
          state_d = (state_q == ST_UNLOAD) ? ST_DONE : ST_CAPTURE;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end else if (cap_s) begin
        if (cap_q == 2'(CAP_CYC - 1)) begin
          cap_d   = 2'd0;
          pat_d   = pat_inc_s[PAT_W-1:0];
          state_d = (pat_inc_s < {1'b0, npat_q}) ? ST_SHIFT : ST_UNLOAD;
        end else begin
          cap_d = cap_q + 2'd1;
        end
      end else begin
        state_d = state_q;
      end
    end
  end

  // FSM state, counters and state-decoded registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      cap_q   <= 2'd0;
      pat_q   <= '0;
      npat_q  <= '0;
      vec_q   <= '0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cap_q   <= cap_d;
      pat_q   <= pat_d;
      npat_q  <= npat_d;
      vec_q   <= vec_d;
      shift_q <= (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
      busy_q  <= (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_UNLOAD) ||
                 (state_d == ST_CAPTURE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign scan_en    = shift_q;
  assign stim_ready = shift_q;
  assign scan_ce    = scan_ce_s;
  assign scan_si    = (xfer_s && (state_q != ST_UNLOAD)) ? stim_si : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pat_num    = pat_q;
  assign vec_num    = vec_q;

  // The pattern being unloaded is one behind pat_num, which advances at capture end.
  scan_cmp #(.NCHAIN(NCHAIN)) u_cmp (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr_s),
    .cmp_en_i   (cmp_en_s),
    .so_i       (scan_so),
    .exp_i      (stim_exp),
    .msk_i      (stim_msk),
    .pat_i      (pat_q - 16'd1),
    .vec_i      (vec_q),
    .fail_cnt_o (fail_cnt),
    .ff_pat_o   (ff_pat),
    .ff_vec_o   (ff_vec),
    .ff_chain_o (ff_chain),
    .ff_vld_o   (ff_vld)
  );

endmodule

// File: tb/tb_scan_pat_engine.sv
// Directed bench for scan_pat_engine with NCHAIN=4, CHAIN_LEN=8, CAP_CYC=1.
`timescale 1ns/1ps
module tb_scan_pat_engine;

  logic        clk = 1'b0;
  logic        rst, start, abort, stim_valid, stim_ready;
  logic [15:0] num_pat;
  logic [3:0]  stim_si, stim_exp, stim_msk, scan_si, scan_so, ff_chain;
  logic        scan_en, scan_ce, busy, done, ff_vld;
  logic [15:0] pat_num, fail_cnt, ff_pat;
  logic [31:0] vec_num, ff_vec;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  scan_pat_engine #(.NCHAIN(4), .CHAIN_LEN(8), .CAP_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pat(num_pat),
    .stim_valid(stim_valid), .stim_ready(stim_ready), .stim_si(stim_si),
    .stim_exp(stim_exp), .stim_msk(stim_msk), .scan_en(scan_en), .scan_ce(scan_ce),
    .scan_si(scan_si), .scan_so(scan_so), .busy(busy), .done(done),
    .pat_num(pat_num), .vec_num(vec_num), .fail_cnt(fail_cnt), .ff_pat(ff_pat),
    .ff_vec(ff_vec), .ff_chain(ff_chain), .ff_vld(ff_vld)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One run; bvec is the bench's own count of scan_ce cycles since start.
  task automatic do_run(input logic [15:0] np, input int bad_vec, input int stall_at,
                        input int stall_len, input logic all_bad, input logic [3:0] msk_val,
                        input int abort_at, input int rst_at, input int sb_at,
                        input logic detail, input int max_cyc);
    int cyc, bvec, stalled;
    logic stall, brk, sb_hit;
    cyc = 0; bvec = 0; stalled = 0; brk = 1'b0; sb_hit = 1'b0;
    num_pat = np; start = 1'b1; stim_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!done && !brk && cyc < max_cyc) begin
      stall      = (bvec == stall_at) && (stalled < stall_len);
      stim_valid = !stall;
      stim_exp   = 4'(bvec * 5 + 3);
      stim_si    = 4'(bvec) ^ 4'hA;
      scan_so    = all_bad ? ~stim_exp : stim_exp;
      if (bvec == bad_vec) begin
        stim_exp = 4'h0;
        scan_so  = 4'h4;
      end
      stim_msk = msk_val;
      abort    = (bvec == abort_at);
      rst      = (bvec == rst_at);
      sb_hit   = (bvec == sb_at) && !stall;
      start    = sb_hit;
      num_pat  = sb_hit ? 16'd0 : np;
      #1;
      if (stall) begin
        check("stall_ce", {31'd0, scan_ce}, 32'd0);
        check("stall_en", {31'd0, scan_en}, 32'd1);
        check("stall_vec", vec_num, 32'(bvec));
        stalled++;
      end
      if (detail && bvec == 2)  check("load_si", {28'd0, scan_si}, {28'd0, stim_si});
      if (detail && bvec == 8) begin
        check("cap_en", {31'd0, scan_en}, 32'd0);
        check("cap_rdy", {31'd0, stim_ready}, 32'd0);
        check("cap_ce", {31'd0, scan_ce}, 32'd1);
      end
      if (detail && bvec == 12) check("shift_si", {28'd0, scan_si}, {28'd0, stim_si});
      if (detail && bvec == 20) begin
        check("unl_si", {28'd0, scan_si}, 32'd0);
        check("unl_rdy", {31'd0, stim_ready}, 32'd1);
      end
      brk = abort || rst;
      @(negedge clk);
      if (!stall) bvec++;
      cyc++;
      if (sb_hit) begin
        start = 1'b0;
        check("busy_start_pat", {16'd0, pat_num}, 32'd0);
        check("busy_start_vec", vec_num, 32'(bvec));
        check("busy_start_busy", {31'd0, busy}, 32'd1);
      end
    end
    abort = 1'b0; rst = 1'b0; start = 1'b0; stim_valid = 1'b0; num_pat = np;
    if (!brk && !done) check("run_timeout", 32'(cyc), 32'(max_cyc + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_pat = 16'd0; stim_valid = 1'b0;
    stim_si = 4'h0; stim_exp = 4'h0; stim_msk = 4'h0; scan_so = 4'h0;
    idle(2);
    rst = 1'b0;
    idle(1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_en", {31'd0, scan_en}, 32'd0);
    check("rst_rdy", {31'd0, stim_ready}, 32'd0);
    check("rst_vec", vec_num, 32'd0);
    check("rst_fail", {16'd0, fail_cnt}, 32'd0);
    check("rst_ffvld", {31'd0, ff_vld}, 32'd0);

    // Clean two-pattern run
    do_run(16'd2, -1, -1, 0, 1'b0, 4'hF, -1, -1, -1, 1'b1, 100);
    idle(1);
    check("clean_vec", vec_num, 32'd26);
    check("clean_fail", {16'd0, fail_cnt}, 32'd0);
    check("clean_done", {31'd0, done}, 32'd1);
    check("clean_busy", {31'd0, busy}, 32'd0);
    check("clean_ffvld", {31'd0, ff_vld}, 32'd0);
    check("clean_pat", {16'd0, pat_num}, 32'd2);

    // Single miscompare on the third SHIFT vector, restarted from DONE
    do_run(16'd2, 11, -1, 0, 1'b0, 4'hF, -1, -1, -1, 1'b0, 100);
    idle(1);
    check("ff1_fail", {16'd0, fail_cnt}, 32'd1);
    check("ff1_pat", {16'd0, ff_pat}, 32'd0);
    check("ff1_vec", ff_vec, 32'd11);
    check("ff1_chain", {28'd0, ff_chain}, 32'h4);
    check("ff1_vld", {31'd0, ff_vld}, 32'd1);

    // Miscompare during UNLOAD belongs to pattern 1
    do_run(16'd2, 22, -1, 0, 1'b0, 4'hF, -1, -1, -1, 1'b0, 100);
    idle(1);
    check("ff2_fail", {16'd0, fail_cnt}, 32'd1);
    check("ff2_pat", {16'd0, ff_pat}, 32'd1);
    check("ff2_vec", ff_vec, 32'd22);

    // Five stall cycles mid-LOAD
    do_run(16'd2, -1, 3, 5, 1'b0, 4'hF, -1, -1, -1, 1'b0, 100);
    idle(1);
    check("stall_final_vec", vec_num, 32'd26);
    check("stall_final_fail", {16'd0, fail_cnt}, 32'd0);

    // Every bit miscompares but mask is zero
    do_run(16'd1, -1, -1, 0, 1'b1, 4'h0, -1, -1, -1, 1'b0, 100);
    idle(1);
    check("mask_vec", vec_num, 32'd17);
    check("mask_fail", {16'd0, fail_cnt}, 32'd0);
    check("mask_ffvld", {31'd0, ff_vld}, 32'd0);

    // Start pulse during LOAD is ignored
    do_run(16'd2, -1, -1, 0, 1'b0, 4'hF, -1, -1, 5, 1'b0, 100);
    idle(1);
    check("sb_final_vec", vec_num, 32'd26);

    // Abort in SHIFT keeps the fail record
    do_run(16'd2, 10, -1, 0, 1'b0, 4'hF, 12, -1, -1, 1'b0, 100);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_en", {31'd0, scan_en}, 32'd0);
    check("abort_rdy", {31'd0, stim_ready}, 32'd0);
    check("abort_fail", {16'd0, fail_cnt}, 32'd1);
    check("abort_ffvec", ff_vec, 32'd10);
    check("abort_ffvld", {31'd0, ff_vld}, 32'd1);

    // Zero patterns from IDLE
    do_run(16'd0, -1, -1, 0, 1'b0, 4'hF, -1, -1, -1, 1'b0, 100);
    check("np0_done", {31'd0, done}, 32'd1);
    check("np0_busy", {31'd0, busy}, 32'd0);
    check("np0_vec", vec_num, 32'd0);
    check("np0_ffvld", {31'd0, ff_vld}, 32'd0);

    // Reset mid-UNLOAD after a recorded fail
    do_run(16'd2, 11, -1, 0, 1'b0, 4'hF, -1, 20, -1, 1'b0, 100);
    stim_valid = 1'b1;
    stim_si    = 4'hF;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_en", {31'd0, scan_en}, 32'd0);
    check("mrst_ce", {31'd0, scan_ce}, 32'd0);
    check("mrst_rdy", {31'd0, stim_ready}, 32'd0);
    check("mrst_si", {28'd0, scan_si}, 32'd0);
    check("mrst_pat", {16'd0, pat_num}, 32'd0);
    check("mrst_vec", vec_num, 32'd0);
    check("mrst_fail", {16'd0, fail_cnt}, 32'd0);
    check("mrst_ffvld", {31'd0, ff_vld}, 32'd0);
    check("mrst_ffpat", {16'd0, ff_pat}, 32'd0);
    check("mrst_ffvec", ff_vec, 32'd0);
    check("mrst_ffchain", {28'd0, ff_chain}, 32'd0);
    stim_valid = 1'b0;
    idle(1);

    // 2500 patterns, all bits miscompare: 20000 compared vectors x 4 bits saturates
    do_run(16'd2500, -1, -1, 0, 1'b1, 4'hF, -1, -1, -1, 1'b0, 30000);
    idle(1);
    check("sat_vec", vec_num, 32'd22508);
    check("sat_fail", {16'd0, fail_cnt}, 32'h0000FFFF);
    check("sat_ffvec", ff_vec, 32'd9);
    check("sat_ffchain", {28'd0, ff_chain}, 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
